dec_err_corr: RTL



---
 rtl/dec_err_corr_if.sv | 40 ++++
 rtl/dec_err_corr.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dec_err_corr_if.sv
// Handshake/bus bundle between the syndrome multiplier, the error
// corrector and the info-extraction stage.
//   master : upstream/downstream side (drives in_* data, out_ready)
//   slave  : the corrector (drives in_ready, out_valid, data_out,
//            num_of_errors)
// Signals:
//   in_valid / in_ready        : input handshake
//   syndrome, codeword         : registered syndrome and matching codeword
//   work_mod                   : 0 -> n=8, 1 -> n=16, 2 -> n=32, else invalid
//   h_matrix                   : active H, bit r*MAX_CODEWORD_WIDTH+j = H[r][j]
//   out_valid / out_ready      : output handshake
//   data_out, num_of_errors    : corrected word and 0/1/2 error class
interface dec_err_corr_if #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int AMBA_WORD          = 32
);
    localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

    logic                                         in_valid;
    logic                                         in_ready;
    logic [MAX_PARITY_WIDTH-1:0]                  syndrome;
    logic [MAX_CODEWORD_WIDTH-1:0]                codeword;
    logic [AMBA_WORD-1:0]                         work_mod;
    logic [MAX_PARITY_WIDTH*MAX_CODEWORD_WIDTH-1:0] h_matrix;
    logic                                         out_valid;
    logic                                         out_ready;
    logic [MAX_CODEWORD_WIDTH-1:0]                data_out;
    logic [1:0]                                   num_of_errors;

    modport master (
        output in_valid, syndrome, codeword, work_mod, h_matrix, out_ready,
        input  in_ready, out_valid, data_out, num_of_errors
    );

    modport slave (
        input  in_valid, syndrome, codeword, work_mod, h_matrix, out_ready,
        output in_ready, out_valid, data_out, num_of_errors
    );
endinterface

// File: rtl/dec_err_corr.sv
// Error classification and single-bit correction stage.
// Accepts a syndrome/codeword pair, classifies the error count
// (0 / 1 / 2+), locates a single error by searching H one column per
// cycle, flips that bit and presents the result on a valid/ready output.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : dec_err_corr_if.slave (input and output handshakes, data, H)
module dec_err_corr #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int AMBA_WORD          = 32
) (
    input  logic              clk,
    input  logic              rst,
    dec_err_corr_if.slave     bus
);
    localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
    localparam int IDX_W            = $clog2(MAX_CODEWORD_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                        state;
    logic [MAX_PARITY_WIDTH-1:0]   syn_q;
    logic [MAX_PARITY_WIDTH-1:0]   mask_q;
    logic [IDX_W-1:0]              last_q;
    logic [IDX_W-1:0]              idx_q;
    logic [MAX_CODEWORD_WIDTH-1:0] data_q;
    logic [1:0]                    nerr_q;
    logic                          in_ready_q;
    logic                          out_valid_q;

    // Mode decode for the word being offered: p-bit syndrome mask,
    // last column index and the overall-parity bit syndrome[p-1].
    logic                          mode_ok;
    logic [MAX_PARITY_WIDTH-1:0]   sel_mask;
    logic [IDX_W-1:0]              sel_last;
    logic                          parity_bit;
    int                            n_sel;
    int                            p_sel;

    always_comb begin
        mode_ok    = 1'b1;
        n_sel      = 8;
        p_sel      = 1;
        sel_mask   = '0;
        parity_bit = 1'b0;
        case (bus.work_mod)
            32'd0: begin n_sel = 8;  p_sel = 4; end
            32'd1: begin n_sel = 16; p_sel = 5; end
            32'd2: begin n_sel = 32; p_sel = 6; end
            default: mode_ok = 1'b0;
        endcase
        if (n_sel > MAX_CODEWORD_WIDTH || p_sel > MAX_PARITY_WIDTH) begin
            mode_ok = 1'b0;
            n_sel   = 1;
            p_sel   = 1;
        end
        for (int r = 0; r < MAX_PARITY_WIDTH; r++) begin
            sel_mask[r] = (r < p_sel);
            if (r == p_sel - 1) begin
                parity_bit = bus.syndrome[r];
            end
        end
        sel_last = IDX_W'(n_sel - 1);
    end

    // Current H column, restricted to the active p rows so that rows
    // beyond the mode's parity width never influence the match.
    logic [MAX_PARITY_WIDTH-1:0] col;
    logic                        col_match;

    always_comb begin
        col = '0;
        for (int r = 0; r < MAX_PARITY_WIDTH; r++) begin
            col[r] = mask_q[r] & bus.h_matrix[r*MAX_CODEWORD_WIDTH + int'(idx_q)];
        end
        col_match = (col == (syn_q & mask_q));
    end

    // Control FSM. All outputs are registered; the search index only
    // advances up to the last active column, so bits at or above n are
    // never flipped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            syn_q       <= '0;
            mask_q      <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            nerr_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        syn_q      <= bus.syndrome;
                        mask_q     <= sel_mask;
                        last_q     <= sel_last;
                        idx_q      <= '0;
                        data_q     <= bus.codeword;
                        in_ready_q <= 1'b0;
                        if (!mode_ok) begin
                            nerr_q      <= 2'd0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if ((bus.syndrome & sel_mask) == '0) begin
                            nerr_q      <= 2'd0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (!parity_bit) begin
                            // Non-zero syndrome with even overall parity: double error.
                            nerr_q      <= 2'd2;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (col_match) begin
                        data_q[idx_q] <= ~data_q[idx_q];
                        nerr_q        <= 2'd1;
                        out_valid_q   <= 1'b1;
                        state         <= DONE;
                    end else if (idx_q == last_q) begin
                        // Odd parity but no column matches: uncorrectable.
                        nerr_q      <= 2'd2;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.data_out      = data_q;
    assign bus.num_of_errors = nerr_q;
endmodule
